// File: rtl/vga_pixel_fetch.sv
// Prefetches RGB565 pixels of the active frame from framebuffer memory into a
// small FIFO and hands one pixel per active-video cycle to the RGB565->RGB888
// expansion stage. Every frame_start restarts the fetch. Responses still in
// flight from the old frame are counted down and dropped. Underflow is sticky.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start       1-cycle pulse before the first active line
//   pixel_req         active-video pixel consumed this cycle
//   mem_rd_req/addr   read request (held until ack) and its word address
//   mem_rd_ack        request accepted this cycle
//   mem_rd_valid/data in-order read return, RGB565 {R5,G6,B5}
//   pixel_out         pixel to the colour expansion stage (1-cycle latency)
//   underflow         sticky: pixel_req seen with the FIFO empty
module vga_pixel_fetch #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FB_BASE     = 0,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] UNDER_COLOR = 16'hF81F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pixel_req,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic [15:0]       pixel_out,
    output logic              underflow
);

    localparam int unsigned PIX_W = 16;
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned SUM_W = LVL_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic [LVL_W-1:0] outst;
    logic [LVL_W-1:0] outst_nxt;
    logic [CNT_W-1:0] pix_cnt;

    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;
    logic             under;
    logic             last_issue;
    logic             req_nxt;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level = wr_ptr - rd_ptr;

    // Next-state, credit and FIFO control.
    always_comb begin
        issue      = mem_rd_req & mem_rd_ack;
        // A return with nothing outstanding belongs to a request lost to reset.
        resp       = mem_rd_valid & (outst != '0);
        push       = resp & ((state == FETCH) || (state == DONE)) & ~frame_start;
        pop        = pixel_req & ~frame_start & (level != '0);
        under      = pixel_req & ~frame_start & (level == '0);
        last_issue = issue & (pix_cnt == CNT_W'(TOTAL - 1));
        outst_nxt  = outst + LVL_W'(issue) - LVL_W'(resp);
        level_nxt  = frame_start ? '0 : (level + LVL_W'(push) - LVL_W'(pop));

        state_nxt = state;
        if (frame_start) begin
            // Anything accepted by memory, including this cycle, must drain first.
            state_nxt = (outst_nxt != '0) ? FLUSH : FETCH;
        end else begin
            case (state)
                FETCH:   if (last_issue) state_nxt = DONE;
                FLUSH:   if (outst_nxt == '0) state_nxt = FETCH;
                default: state_nxt = state;
            endcase
        end

        // Computed from next-cycle values so the request never over-commits the
        // FIFO; the sum cannot grow while a request waits, so it holds until ack.
        req_nxt = (state_nxt == FETCH) & ~frame_start & ~last_issue &
                  ((SUM_W'(level_nxt) + SUM_W'(outst_nxt)) < SUM_W'(FIFO_DEPTH));
    end

    // State, request, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= ADDR_W'(FB_BASE);
            pix_cnt     <= '0;
            outst       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pixel_out   <= '0;
            underflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_rd_req <= req_nxt;
            outst      <= outst_nxt;
            if (frame_start) begin
                mem_rd_addr <= ADDR_W'(FB_BASE);
                pix_cnt     <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                underflow   <= 1'b0;
            end else begin
                if (issue) begin
                    mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                    pix_cnt     <= pix_cnt + CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + LVL_W'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + LVL_W'(1);
                    pixel_out <= fifo_mem[rd_ptr[PTR_W-1:0]];
                end else if (under) begin
                    pixel_out <= UNDER_COLOR;
                    underflow <= 1'b1;
                end
            end
        end
    end

    // Pixel storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= mem_rd_data;
        end
    end

    // The credit rule keeps a return from ever arriving with the FIFO full.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push && (level == LVL_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: 4x8 frame based near the top of the
// address space so the fetch address wraps, with a latency-programmable memory.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 8;
    localparam int unsigned AW    = 19;
    localparam int unsigned BASE  = 32'h7FFF8;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] UCOL  = 16'hF81F;
    localparam int          NVEC  = 35;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pixel_req = 1'b0;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_ack = 1'b0;
    logic          mem_rd_valid = 1'b0;
    logic [15:0]   mem_rd_data = 16'h0;
    logic [15:0]   pixel_out;
    logic          underflow;

    vga_pixel_fetch #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .ADDR_W     (AW),
        .FB_BASE    (BASE),
        .FIFO_DEPTH (DEPTH),
        .UNDER_COLOR(UCOL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_req   (pixel_req),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .pixel_out   (pixel_out),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Memory model: acks every request, returns tag + pixel index after lat cycles.
    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } rsp_t;

    rsp_t        q[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_acc = 0;
    int unsigned acc_base = 0;
    logic [15:0] mem_tag = 16'h0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (q.size() != 0 && q[0].due <= cyc) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= q[0].data;
            void'(q.pop_front());
        end else begin
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= 16'hDEAD;
        end
        if (mem_rd_req && rst_n) begin
            mem_rd_ack <= 1'b1;
            q.push_back('{due: cyc + lat, data: mem_tag + 16'(mem_rd_addr - AW'(BASE))});
            n_acc <= n_acc + 1;
        end else begin
            mem_rd_ack <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle; returns just after the following negedge.
    task automatic step(input logic fs, input logic pr);
        frame_start = fs;
        pixel_req   = pr;
        @(negedge clk);
        #1;
        frame_start = 1'b0;
        pixel_req   = 1'b0;
    endtask

    function automatic logic [31:0] exp_addr(input int unsigned k);
        logic [AW-1:0] a;
        a = AW'(BASE + k);
        return 32'(a);
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic wait_mem_idle(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int unsigned target, input string name);
        int n;
        n = 0;
        while ((n_acc - acc_base) < target && n < 100) begin
            step(1'b0, 1'b0);
            n++;
        end
        check(name, 32'(n_acc - acc_base), 32'(target));
    endtask

    typedef struct {
        logic        fs;
        logic        pr;
        logic [15:0] pix;
        logic        uf;
    } vec_t;

    vec_t tbl[NVEC];

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Whole-frame drain with zero-latency memory: pops, one hold, then underflow.
        tbl[0] = '{fs: 1'b0, pr: 1'b1, pix: 16'd0, uf: 1'b0};
        tbl[1] = '{fs: 1'b0, pr: 1'b1, pix: 16'd1, uf: 1'b0};
        tbl[2] = '{fs: 1'b0, pr: 1'b0, pix: 16'd1, uf: 1'b0};
        for (int k = 2; k < 32; k++) tbl[k + 1] = '{fs: 1'b0, pr: 1'b1, pix: 16'(k), uf: 1'b0};
        tbl[33] = '{fs: 1'b0, pr: 1'b1, pix: UCOL, uf: 1'b1};
        tbl[34] = '{fs: 1'b0, pr: 1'b0, pix: UCOL, uf: 1'b1};

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        #1;
        check("rst_pixel_out", 32'(pixel_out), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_req", 32'(mem_rd_req), 32'd0);
        check("rst_addr", 32'(mem_rd_addr), exp_addr(0));
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_no_req", 32'(mem_rd_req), 32'd0);

        // Pixel request straight out of reset underflows and stays flagged.
        step(1'b0, 1'b1);
        check("uf_exit_pix", 32'(pixel_out), 32'(UCOL));
        check("uf_exit_flag", 32'(underflow), 32'd1);
        idle_cycles(3);
        check("uf_sticky_flag", 32'(underflow), 32'd1);
        check("uf_sticky_pix", 32'(pixel_out), 32'(UCOL));

        // Zero-latency memory fill: stops at 16 credits, address wraps past 2^19.
        lat     = 1;
        mem_tag = 16'h0000;
        step(1'b1, 1'b0);
        check("fs_clears_uf", 32'(underflow), 32'd0);
        check("fs_pix_hold", 32'(pixel_out), 32'(UCOL));
        check("fs_req_drop", 32'(mem_rd_req), 32'd0);
        check("fs_addr_base", 32'(mem_rd_addr), exp_addr(0));
        idle_cycles(40);
        check("fill_req_stop", 32'(mem_rd_req), 32'd0);
        check("fill_addr", 32'(mem_rd_addr), exp_addr(16));

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].fs, tbl[i].pr);
            check($sformatf("tbl%0d_pix", i), 32'(pixel_out), 32'(tbl[i].pix));
            check($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(tbl[i].uf));
        end
        check("end_addr", 32'(mem_rd_addr), exp_addr(32));
        check("end_no_req", 32'(mem_rd_req), 32'd0);

        // frame_start wins over pixel_req on an empty FIFO.
        step(1'b1, 1'b1);
        check("fspr_empty_pix", 32'(pixel_out), 32'(UCOL));
        check("fspr_empty_uf", 32'(underflow), 32'd0);
        check("fspr_empty_addr", 32'(mem_rd_addr), exp_addr(0));
        idle_cycles(40);
        wait_mem_idle("drain_a");

        // Latency 6: requests stop once level + outstanding reaches 16.
        lat     = 6;
        mem_tag = 16'h0100;
        step(1'b1, 1'b0);
        acc_base = n_acc;
        wait_acc(16, "lat6_16_reqs");
        step(1'b0, 1'b0);
        check("lat6_req_drop", 32'(mem_rd_req), 32'd0);
        check("lat6_addr", 32'(mem_rd_addr), exp_addr(16));
        idle_cycles(20);
        check("lat6_full_no_req", 32'(mem_rd_req), 32'd0);
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 1'b1);
            check($sformatf("lat6_pix%0d", k), 32'(pixel_out), 32'(16'h0100 + 16'(k)));
            check($sformatf("lat6_uf%0d", k), 32'(underflow), 32'd0);
        end
        wait_mem_idle("drain_b");

        // Restart with 5 reads in flight: their returns must be discarded.
        mem_tag = 16'h1000;
        step(1'b1, 1'b0);
        acc_base = n_acc;
        wait_acc(5, "flush_5_reqs");
        mem_tag = 16'h2000;
        step(1'b1, 1'b0);
        check("flush_req_drop", 32'(mem_rd_req), 32'd0);
        check("flush_addr_base", 32'(mem_rd_addr), exp_addr(0));
        idle_cycles(3);
        check("flush_no_req", 32'(mem_rd_req), 32'd0);
        idle_cycles(40);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            check($sformatf("newframe_pix%0d", k), 32'(pixel_out), 32'(16'h2000 + 16'(k)));
            check($sformatf("newframe_uf%0d", k), 32'(underflow), 32'd0);
        end

        // frame_start and pixel_req together with a non-empty FIFO.
        step(1'b1, 1'b1);
        check("fspr_pix_hold", 32'(pixel_out), 32'h2002);
        check("fspr_uf", 32'(underflow), 32'd0);
        check("fspr_addr", 32'(mem_rd_addr), exp_addr(0));
        step(1'b0, 1'b1);
        check("fspr_fifo_empty_pix", 32'(pixel_out), 32'(UCOL));
        check("fspr_fifo_empty_uf", 32'(underflow), 32'd1);
        idle_cycles(40);
        wait_mem_idle("drain_c");

        // Reset pulse mid-fetch with reads outstanding.
        mem_tag = 16'h3000;
        step(1'b1, 1'b0);
        acc_base = n_acc;
        step(1'b0, 1'b1);
        check("pre_rst_uf", 32'(underflow), 32'd1);
        wait_acc(3, "pre_rst_reqs");
        rst_n = 1'b0;
        #1;
        check("midrst_pix", 32'(pixel_out), 32'd0);
        check("midrst_uf", 32'(underflow), 32'd0);
        check("midrst_req", 32'(mem_rd_req), 32'd0);
        check("midrst_addr", 32'(mem_rd_addr), exp_addr(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(12);
        check("postrst_no_req", 32'(mem_rd_req), 32'd0);
        check("postrst_pix", 32'(pixel_out), 32'd0);
        step(1'b0, 1'b1);
        check("postrst_empty_pix", 32'(pixel_out), 32'(UCOL));
        check("postrst_empty_uf", 32'(underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
